// File: rtl/snake_turn_controller.sv
// Two-player turn sequencer for the snake game.
// Runs a READY countdown and a PLAY round for player 1, a one-cycle SWITCH,
// then the same for player 2, and finally latches both scores and the winner.
module snake_turn_controller #(
  parameter logic [31:0] READY_CYCLES = 32'd50_000_000,
  parameter logic [7:0]  WIN_SCORE    = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  input  logic [7:0] score_in,
  output logic       score_reset,
  output logic       snake_init,
  output logic       play_en,
  output logic       active_player,
  output logic [7:0] p1_score,
  output logic [7:0] p2_score,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [2:0] state_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StReady1 = 3'd1;
  localparam logic [2:0] StPlay1  = 3'd2;
  localparam logic [2:0] StSwitch = 3'd3;
  localparam logic [2:0] StReady2 = 3'd4;
  localparam logic [2:0] StPlay2  = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  localparam logic [31:0] ReadyLoad = READY_CYCLES - 32'd1;

  logic [2:0]  state_q, state_d;
  logic [31:0] counter_q, counter_d;
  logic [7:0]  p1_q, p1_d;
  logic [7:0]  p2_q, p2_d;
  logic [1:0]  winner_q, winner_d;
  logic        start_q;
  logic        start_rise;
  logic        play_end;

  assign start_rise = start & ~start_q;
  // Round end only counts while unpaused; collision and win share one transition.
  assign play_end   = ~pause & (collision | (score_in >= WIN_SCORE));

  // Next-state, countdown and score/winner latching.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    winner_d  = winner_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_rise) begin
          state_d   = StReady1;
          counter_d = ReadyLoad;
          p1_d      = 8'd0;
          p2_d      = 8'd0;
          winner_d  = 2'b00;
        end
      end
      StReady1: begin
        if (counter_q == 32'd0) state_d = StPlay1;
        else                    counter_d = counter_q - 32'd1;
      end
      StPlay1: begin
        if (play_end) begin
          p1_d    = score_in;
          state_d = StSwitch;
        end
      end
      StSwitch: begin
        state_d   = StReady2;
        counter_d = ReadyLoad;
      end
      StReady2: begin
        if (counter_q == 32'd0) state_d = StPlay2;
        else                    counter_d = counter_q - 32'd1;
      end
      StPlay2: begin
        if (play_end) begin
          p2_d    = score_in;
          state_d = StDone;
          // Compare against the score captured this cycle, not the old p2 register.
          if (p1_q > score_in)      winner_d = 2'b01;
          else if (score_in > p1_q) winner_d = 2'b10;
          else                      winner_d = 2'b11;
        end
      end
      default: begin
        state_d   = StIdle;
        counter_d = 32'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      counter_q <= 32'd0;
      p1_q      <= 8'd0;
      p2_q      <= 8'd0;
      winner_q  <= 2'b00;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      winner_q  <= winner_d;
      start_q   <= start;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    score_reset   = (state_q == StReady1) | (state_q == StReady2);
    snake_init    = (state_q == StReady1) | (state_q == StReady2);
    play_en       = ((state_q == StPlay1) | (state_q == StPlay2)) & ~pause;
    active_player = (state_q == StReady2) | (state_q == StPlay2);
    game_over     = (state_q == StDone);
    winner        = (state_q == StDone) ? winner_q : 2'b00;
    p1_score      = p1_q;
    p2_score      = p2_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_snake_turn_controller.sv
// Directed bench for snake_turn_controller with a game-level reference model.
module tb_snake_turn_controller;

  localparam int unsigned ReadyN = 4;
  localparam logic [7:0]  WinS   = 8'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       collision = 1'b0;
  logic [7:0] score_in = 8'd0;
  logic       score_reset, snake_init, play_en, active_player, game_over;
  logic [7:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  snake_turn_controller #(
    .READY_CYCLES(32'd4),
    .WIN_SCORE   (8'd5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause        (pause),
    .collision    (collision),
    .score_in     (score_in),
    .score_reset  (score_reset),
    .snake_init   (snake_init),
    .play_en      (play_en),
    .active_player(active_player),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .winner       (winner),
    .game_over    (game_over),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game-level model: phase number, cycles left in the countdown, latched scores.
  int         m_phase;
  int         m_left;
  logic [7:0] m_p1, m_p2;
  logic       m_prev_start;

  function automatic logic [1:0] win_of(input logic [7:0] a, input logic [7:0] b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b11;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase      <= 0;
      m_left       <= 0;
      m_p1         <= 8'd0;
      m_p2         <= 8'd0;
      m_prev_start <= 1'b0;
    end else begin
      m_prev_start <= start;
      if (m_phase == 0 || m_phase == 6) begin
        if (start && !m_prev_start) begin
          m_phase <= 1;
          m_left  <= ReadyN;
          m_p1    <= 8'd0;
          m_p2    <= 8'd0;
        end
      end else if (m_phase == 1 || m_phase == 4) begin
        if (m_left == 1) m_phase <= m_phase + 1;
        else             m_left  <= m_left - 1;
      end else if (m_phase == 2 || m_phase == 5) begin
        if (!pause && (collision || score_in >= WinS)) begin
          if (m_phase == 2) m_p1 <= score_in;
          else              m_p2 <= score_in;
          m_phase <= (m_phase == 2) ? 3 : 6;
        end
      end else if (m_phase == 3) begin
        m_phase <= 4;
        m_left  <= ReadyN;
      end
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst) begin
      check("state_o", 32'(state_o), 32'(m_phase));
      check("score_reset", 32'(score_reset), 32'(m_phase == 1 || m_phase == 4));
      check("snake_init", 32'(snake_init), 32'(m_phase == 1 || m_phase == 4));
      check("play_en", 32'(play_en), 32'((m_phase == 2 || m_phase == 5) && !pause));
      check("active_player", 32'(active_player), 32'(m_phase == 4 || m_phase == 5));
      check("game_over", 32'(game_over), 32'(m_phase == 6));
      check("p1_score", 32'(p1_score), 32'(m_p1));
      check("p2_score", 32'(p2_score), 32'(m_p2));
      check("winner", 32'(winner), 32'((m_phase == 6) ? win_of(m_p1, m_p2) : 2'b00));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_flags"}, 32'({score_reset, snake_init, play_en, active_player, game_over}),
          32'd0);
    check({tag, "_scores"}, 32'({p1_score, p2_score}), 32'd0);
    check({tag, "_winner"}, 32'(winner), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    #12;
    check_all_zero("reset_initial");
    rst = 1'b1;
    tick();

    // start rise from IDLE: 4 cycles of READY1, then PLAY1
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ready1_score_reset", 32'(score_reset), 32'd1);
      check("ready1_snake_init", 32'(snake_init), 32'd1);
      tick();
    end
    check("play1_state", 32'(state_o), 32'd2);
    check("play1_play_en", 32'(play_en), 32'd1);

    // PLAY1 ends on collision with score 3
    score_in  = 8'd3;
    collision = 1'b1;
    tick();
    collision = 1'b0;
    score_in  = 8'd0;
    check("switch_state", 32'(state_o), 32'd3);
    check("switch_p1", 32'(p1_score), 32'd3);
    check("switch_play_en", 32'(play_en), 32'd0);
    check("switch_active", 32'(active_player), 32'd0);
    check("switch_score_reset", 32'(score_reset), 32'd0);
    tick();
    check("ready2_state", 32'(state_o), 32'd4);
    check("ready2_active", 32'(active_player), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("play2_state", 32'(state_o), 32'd5);

    // PLAY2 ends on reaching WIN_SCORE
    score_in = 8'd4;
    tick();
    check("play2_below_win", 32'(state_o), 32'd5);
    score_in = 8'd5;
    tick();
    check("done_state", 32'(state_o), 32'd6);
    check("done_p2", 32'(p2_score), 32'd5);
    check("done_winner_p2", 32'(winner), 32'b10);
    check("done_game_over", 32'(game_over), 32'd1);
    score_in = 8'd0;

    // start in DONE clears scores; then play a tie with start held high
    start = 1'b1;
    tick();
    check("restart_state", 32'(state_o), 32'd1);
    check("restart_scores", 32'({p1_score, p2_score}), 32'd0);
    check("restart_winner", 32'(winner), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    score_in  = 8'd2;
    collision = 1'b1;
    tick();
    collision = 1'b0;
    check("tie_p1", 32'(p1_score), 32'd2);
    tick();
    for (int i = 0; i < 4; i++) tick();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    check("tie_state", 32'(state_o), 32'd6);
    check("tie_winner", 32'(winner), 32'b11);
    tick();
    check("held_start_no_retrigger", 32'(state_o), 32'd6);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tie_restart_state", 32'(state_o), 32'd1);
    check("tie_restart_scores", 32'({p1_score, p2_score}), 32'd0);

    // pause in PLAY1 blocks collision and win condition
    for (int i = 0; i < 4; i++) tick();
    pause     = 1'b1;
    collision = 1'b1;
    score_in  = 8'd7;
    #1;
    check("pause_play_en", 32'(play_en), 32'd0);
    tick();
    check("pause_hold_state", 32'(state_o), 32'd2);
    tick();
    check("pause_hold_state2", 32'(state_o), 32'd2);
    check("pause_p1", 32'(p1_score), 32'd0);
    pause     = 1'b0;
    collision = 1'b0;
    score_in  = 8'd1;
    #1;
    check("unpause_play_en", 32'(play_en), 32'd1);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    score_in  = 8'd0;
    check("unpause_switch", 32'(state_o), 32'd3);
    check("unpause_p1", 32'(p1_score), 32'd1);

    // asynchronous reset in the middle of PLAY2
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset_state", 32'(state_o), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_play2");
    #10;
    rst = 1'b1;
    tick();
    check("post_reset_idle", 32'(state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
